// File: rtl/c1541_sd_seq.sv
// c1541_sd_seq
//   Splits one level-style multi-block track request from the 1541 track
//   loader/saver into consecutive single-block SD transfers. It holds sd_ack
//   for the whole track and generates track-buffer byte addresses plus write
//   strobes for every byte moved.
//
//   Optional feature: define C1541_SD_SEQ_RETRY_EN to re-issue a failing block
//   (short byte count or blk_err) up to two extra times before flagging err.
//
// Ports
//   clk, reset_n            system clock, asynchronous active-low reset
//   sd_lba, sd_blk_cnt      first LBA and block count minus one (track side)
//   sd_rd, sd_wr            level requests, held until sd_ack is seen high
//   sd_ack                  high for the whole multi-block transfer
//   blk_lba, blk_rd, blk_wr single-block request to the card controller
//   blk_ack, blk_err        controller busy flag / error (valid on ack fall)
//   byte_stb                one pulse per byte moved
//   buff_addr, buff_we      registered track-buffer address and write strobe
//   busy, err               sequencer active, sticky status of last transfer
module c1541_sd_seq #(
    parameter  int unsigned BLK_BYTES = 512,
    parameter  int unsigned MAX_BLKS  = 32,
    localparam int unsigned OFF_W     = $clog2(BLK_BYTES),
    localparam int unsigned IDX_W     = $clog2(MAX_BLKS),
    localparam int unsigned AW        = OFF_W + IDX_W
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [31:0]   sd_lba,
    input  logic [5:0]    sd_blk_cnt,
    input  logic          sd_rd,
    input  logic          sd_wr,
    output logic          sd_ack,
    output logic [31:0]   blk_lba,
    output logic          blk_rd,
    output logic          blk_wr,
    input  logic          blk_ack,
    input  logic          blk_err,
    input  logic          byte_stb,
    output logic [AW-1:0] buff_addr,
    output logic          buff_we,
    output logic          busy,
    output logic          err
);
    localparam int unsigned      CNT_W   = OFF_W + 1;
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(BLK_BYTES);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_BLKS - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, XFER, NEXT, DONE} state_t;
    state_t state, state_d;

    logic             rd_q, wr_q, dir_wr, blk_err_q;
    logic [31:0]      lba_q;
    logic [IDX_W-1:0] cnt_q, blk_idx;
    logic [CNT_W-1:0] byte_cnt;
    logic             req_seen, blk_fail, last_blk, retry_now;

    assign req_seen = rd_q | wr_q;
    // An overrun saturates byte_cnt at FULL+1, so it also reads as a failure.
    assign blk_fail = (byte_cnt != FULL) | blk_err_q;
    assign last_blk = (blk_idx == cnt_q);

`ifdef C1541_SD_SEQ_RETRY_EN
    logic [1:0] retry_cnt;
    assign retry_now = blk_fail && (retry_cnt != 2'd2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            retry_cnt <= '0;
        else if (state == IDLE || (state == NEXT && !retry_now))
            retry_cnt <= '0;
        else if (state == NEXT)
            retry_cnt <= retry_cnt + 2'd1;
    end
`else
    assign retry_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (req_seen) state_d = ISSUE;
            ISSUE:   if ((blk_rd | blk_wr) && blk_ack) state_d = XFER;
            XFER:    if (!blk_ack) state_d = NEXT;
            NEXT:    state_d = (!retry_now && last_blk) ? DONE : ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            dir_wr    <= 1'b0;
            blk_err_q <= 1'b0;
            lba_q     <= '0;
            cnt_q     <= '0;
            blk_idx   <= '0;
            byte_cnt  <= '0;
            sd_ack    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            blk_lba   <= '0;
            blk_rd    <= 1'b0;
            blk_wr    <= 1'b0;
            buff_addr <= '0;
            buff_we   <= 1'b0;
        end else begin
            // Requests are registered first, which gives the one-cycle gap
            // between the request edge and sd_ack.
            rd_q    <= sd_rd;
            wr_q    <= sd_wr;
            buff_we <= 1'b0;
            case (state)
                IDLE: if (req_seen) begin
                    lba_q    <= sd_lba;
                    dir_wr   <= wr_q;
                    blk_idx  <= '0;
                    byte_cnt <= '0;
                    sd_ack   <= 1'b1;
                    busy     <= 1'b1;
                    if (32'(sd_blk_cnt) > MAX_BLKS - 1) begin
                        cnt_q <= IDX_MAX;
                        err   <= 1'b1;
                    end else begin
                        cnt_q <= IDX_W'(sd_blk_cnt);
                        err   <= 1'b0;
                    end
                end
                ISSUE: begin
                    blk_lba <= lba_q + 32'(blk_idx);
                    // The ack is only honoured once our own request is up.
                    if (blk_rd | blk_wr) begin
                        if (blk_ack) begin
                            blk_rd <= 1'b0;
                            blk_wr <= 1'b0;
                        end
                    end else begin
                        blk_rd <= ~dir_wr;
                        blk_wr <= dir_wr;
                    end
                end
                XFER: begin
                    if (byte_stb) begin
                        if (byte_cnt < FULL) begin
                            buff_addr <= {blk_idx, byte_cnt[OFF_W-1:0]};
                            buff_we   <= ~dir_wr;
                            byte_cnt  <= byte_cnt + CNT_W'(1);
                        end else begin
                            byte_cnt <= FULL + CNT_W'(1);
                        end
                    end
                    if (!blk_ack) blk_err_q <= blk_err;
                end
                NEXT: begin
                    byte_cnt <= '0;
                    if (!retry_now) begin
                        err <= err | blk_fail;
                        if (!last_blk) blk_idx <= blk_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    sd_ack <= 1'b0;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_c1541_sd_seq.sv
// Testbench for c1541_sd_seq: randomized controller model plus queue-based
// scoreboard. Expected requests, buffer writes and end-of-sequence status are
// computed per transaction from block-level arithmetic and popped by a monitor.
module tb_c1541_sd_seq;
    localparam int BLK  = 512;
    localparam int MAXB = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] sd_lba = '0;
    logic [5:0]  sd_blk_cnt = '0;
    logic        sd_rd = 1'b0, sd_wr = 1'b0;
    logic        sd_ack, blk_rd, blk_wr, buff_we, busy, err;
    logic [31:0] blk_lba;
    logic        blk_ack, blk_err, byte_stb;
    logic [13:0] buff_addr;

    c1541_sd_seq #(.BLK_BYTES(BLK), .MAX_BLKS(MAXB)) dut (
        .clk(clk), .reset_n(reset_n), .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .blk_lba(blk_lba),
        .blk_rd(blk_rd), .blk_wr(blk_wr), .blk_ack(blk_ack), .blk_err(blk_err),
        .byte_stb(byte_stb), .buff_addr(buff_addr), .buff_we(buff_we),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] lba; logic wr; } req_t;
    typedef struct { logic err; logic [13:0] addr; } done_t;
    typedef struct { int bytes; logic berr; } plan_t;

    req_t        exp_req_q[$];
    logic [13:0] exp_we_q[$];
    done_t       exp_done_q[$];
    plan_t       plan_q[$];

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic miss(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event not seen or not expected (cycle %0d)", name, cyc);
    endtask

    function automatic plan_t make_plan(input int mode, input int b, input int tries);
        plan_t p;
        p.bytes = BLK;
        p.berr  = 1'b0;
        case (mode)
            1: if ($urandom_range(5) == 0) begin
                   if ($urandom_range(1) == 1) p.bytes = int'($urandom_range(BLK - 1, 1));
                   else                        p.berr  = 1'b1;
               end
            2: if (b == 3 && tries == 0) p.bytes = 100;
            3: p.bytes = 520;
            default: ;
        endcase
        return p;
    endfunction

    // Controller model: acks each request, moves the planned number of bytes.
    initial begin
        int phase, dly, rem;
        plan_t p;
        phase = 0; dly = 0; rem = 0;
        p.bytes = BLK; p.berr = 1'b0;
        blk_ack = 1'b0; blk_err = 1'b0; byte_stb = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                phase = 0; blk_ack = 1'b0; blk_err = 1'b0; byte_stb = 1'b0;
            end else begin
                case (phase)
                    0: begin
                        blk_err = 1'b0;
                        if (blk_rd | blk_wr) begin
                            if (plan_q.size() > 0) p = plan_q.pop_front();
                            else begin p.bytes = BLK; p.berr = 1'b0; end
                            dly = int'($urandom_range(2));
                            phase = 1;
                        end
                    end
                    1: if (dly == 0) begin blk_ack = 1'b1; phase = 2; end
                       else dly--;
                    2: if (!(blk_rd | blk_wr)) begin rem = p.bytes; phase = 3; end
                    default: begin
                        if (rem > 0) begin
                            byte_stb = ($urandom_range(7) != 0);
                            if (byte_stb) rem--;
                        end else begin
                            byte_stb = 1'b0;
                            blk_err  = p.berr;
                            blk_ack  = 1'b0;
                            phase    = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        logic req_p, ack_p, sdack_p;
        int ack_low_cyc;
        req_t r;
        done_t d;
        req_p = 1'b0; ack_p = 1'b0; sdack_p = 1'b0; ack_low_cyc = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                req_p = 1'b0; ack_p = 1'b0; sdack_p = 1'b0;
            end else begin
                if ((blk_rd | blk_wr) && !req_p) begin
                    if (exp_req_q.size() == 0) miss("blk_req_unexpected");
                    else begin
                        r = exp_req_q.pop_front();
                        check("blk_lba", blk_lba, r.lba);
                        check("blk_dir", 32'({blk_wr, blk_rd}), 32'({r.wr, ~r.wr}));
                    end
                end
                if (buff_we) begin
                    if (exp_we_q.size() == 0) miss("buff_we_unexpected");
                    else check("buff_addr", 32'(buff_addr), 32'(exp_we_q.pop_front()));
                end
                if (ack_p && !blk_ack) ack_low_cyc = cyc;
                if (sdack_p && !sd_ack) begin
                    if (exp_done_q.size() == 0) miss("sd_ack_fall_unexpected");
                    else begin
                        d = exp_done_q.pop_front();
                        check("err", 32'(err), 32'(d.err));
                        check("buff_addr_final", 32'(buff_addr), 32'(d.addr));
                        check("busy_after_done", 32'(busy), 32'(0));
                        check("sd_ack_fall_delay", 32'(cyc - ack_low_cyc), 32'(3));
                    end
                end
                req_p = blk_rd | blk_wr; ack_p = blk_ack; sdack_p = sd_ack;
            end
        end
    end

    // Builds the expected outcome, then drives the request until sd_ack.
    task automatic launch(input logic [31:0] lba, input int cnt, input logic rd,
                          input logic wr, input int mode);
        int nblk, tries, k, start;
        logic e_err, ok, good, seen;
        plan_t p;
        req_t r;
        done_t d;
        e_err = (cnt > MAXB - 1);
        nblk  = e_err ? MAXB : cnt + 1;
        d.addr = '0;
        for (int b = 0; b < nblk; b++) begin
            tries = 0;
            ok = 1'b0;
            while (!ok) begin
                p = make_plan(mode, b, tries);
                plan_q.push_back(p);
                r.lba = lba + 32'(b);
                r.wr  = wr;
                exp_req_q.push_back(r);
                k = (p.bytes > BLK) ? BLK : p.bytes;
                if (!wr) for (int j = 0; j < k; j++) exp_we_q.push_back(14'(b * BLK + j));
                d.addr = 14'(b * BLK + k - 1);
                good = (p.bytes == BLK) && !p.berr;
                tries++;
`ifdef C1541_SD_SEQ_RETRY_EN
                ok = good || (tries == 3);
`else
                ok = 1'b1;
`endif
                if (ok && !good) e_err = 1'b1;
            end
        end
        d.err = e_err;
        exp_done_q.push_back(d);

        @(posedge clk); #1;
        sd_lba = lba; sd_blk_cnt = 6'(cnt); sd_rd = rd; sd_wr = wr;
        start = cyc;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = sd_ack;
        end
        check("sd_ack_latency", seen ? 32'(cyc - start) : 32'(999), 32'(2));
        @(posedge clk); #1;
        sd_rd = 1'b0; sd_wr = 1'b0;
        sd_lba = $urandom; sd_blk_cnt = 6'($urandom);
    endtask

    task automatic finish_seq();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 40000 && !done; i++) begin
            @(negedge clk);
            done = !sd_ack;
        end
        if (!done) miss("sequence_timeout");
        repeat (3) @(posedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sd_ack"}, 32'(sd_ack), 32'(0));
        check({tag, "_blk_rd"}, 32'(blk_rd), 32'(0));
        check({tag, "_blk_wr"}, 32'(blk_wr), 32'(0));
        check({tag, "_buff_we"}, 32'(buff_we), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_err"}, 32'(err), 32'(0));
        check({tag, "_blk_lba"}, blk_lba, 32'(0));
        check({tag, "_buff_addr"}, 32'(buff_addr), 32'(0));
    endtask

    initial begin
        logic hit;
        int  dir;
        #23;
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // Track 17 read: 19 blocks from LBA 0x147.
        launch(32'h0000_0147, 18, 1'b1, 1'b0, 0); finish_seq();
        // Full-buffer write: 32 blocks from LBA 5.
        launch(32'h0000_0005, 31, 1'b0, 1'b1, 0); finish_seq();
        // Both directions requested: write wins.
        launch(32'h0001_0000, 2, 1'b1, 1'b1, 0); finish_seq();
        // Block 3 short.
        launch(32'h0000_0200, 5, 1'b1, 1'b0, 2); finish_seq();
        // Overrun: 520 strobes in one block.
        launch(32'h0000_0300, 0, 1'b1, 1'b0, 3); finish_seq();
        // Count beyond buffer capacity is clamped.
        launch(32'h0000_0400, 40, 1'b0, 1'b1, 0); finish_seq();
        // Randomized sequences, first one wraps the LBA.
        launch(32'hFFFF_FFFE, 3, 1'b1, 1'b0, 1); finish_seq();
        for (int t = 0; t < 4; t++) begin
            dir = int'($urandom_range(1));
            launch($urandom, int'($urandom_range(4)), dir == 0, dir == 1, 1);
            finish_seq();
        end

        // Reset in the middle of block 5 of a 10-block read.
        launch(32'h0000_1000, 9, 1'b1, 1'b0, 0);
        hit = 1'b0;
        for (int i = 0; i < 20000 && !hit; i++) begin
            @(negedge clk);
            hit = buff_we && (buff_addr >= 14'(5 * BLK + 40));
        end
        if (!hit) miss("block5_reached");
        #2 reset_n = 1'b0;
        #1 check_all_zero("midreset");
        exp_req_q.delete(); exp_we_q.delete(); exp_done_q.delete(); plan_q.delete();
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        launch(32'h0000_2000, 1, 1'b1, 1'b0, 0); finish_seq();

        check("exp_queues_empty",
              32'(exp_req_q.size() + exp_we_q.size() + exp_done_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/c1541_sd_seq.md
# c1541_sd_seq

Multi-block SD request sequencer sitting directly downstream of the 1541 track loader/saver. It accepts one level-style track request, given as start LBA, block count and read/write, and splits it into consecutive single-block transfers for the SD card controller. It returns one `sd_ack` window spanning the whole track. It also generates the track-buffer byte address and write strobe for every transferred byte.

## Interface
Parameters:
- `BLK_BYTES`, 512: bytes per SD block; must be a power of two.
- `MAX_BLKS`, 32: track-buffer capacity in blocks; buffer address width is log2(`MAX_BLKS`*`BLK_BYTES`), 14 at defaults.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset: asynchronous, active-low.
- `sd_lba`  in  32  first block LBA, from the track stage.
- `sd_blk_cnt`  in  6  block count minus one.
- `sd_rd`  in  1  read request, level; held until `sd_ack` is seen high.
- `sd_wr`  in  1  write request, level; same rules as `sd_rd`.
- `sd_ack`  out  1  high for the whole multi-block transfer.
- `blk_lba`  out  32  LBA of the current single-block transfer.
- `blk_rd`  out  1  single-block read request to the card controller.
- `blk_wr`  out  1  single-block write request to the card controller.
- `blk_ack`  in  1  controller busy with the current block; its falling edge means the block is finished.
- `blk_err`  in  1  controller error flag; valid on the `blk_ack` falling edge.
- `byte_stb`  in  1  one pulse per byte moved, in either direction.
- `buff_addr`  out  14  track-buffer byte address.
- `buff_we`  out  1  buffer write strobe; asserted on reads only.
- `busy`  out  1  sequencer not idle.
- `err`  out  1  sticky status of the last transfer.

## Operation
- FSM states: IDLE, ISSUE, XFER, NEXT, DONE.
- IDLE:
  - Samples `sd_wr`, then `sd_rd`; write has priority if both are high.
  - On a request, latches `sd_lba`, `sd_blk_cnt` and the direction; clears `blk_idx`, `byte_cnt` and `err`.
  - Asserts `sd_ack` and `busy`, then moves to ISSUE.
- ISSUE:
  - Drives `blk_lba` = latched LBA + `blk_idx` (32-bit add, wraps modulo 2^32).
  - Asserts `blk_rd` or `blk_wr`.
  - Deasserts the request on the first cycle `blk_ack`=1, then moves to XFER.
- XFER:
  - Each `byte_stb` advances `byte_cnt`.
  - `buff_addr` = {`blk_idx`[4:0], `byte_cnt`[8:0]}.
  - `buff_we` = `byte_stb` while reading.
  - Strobes beyond `BLK_BYTES` in one block are ignored: no write, address frozen at the last byte, `err` set.
  - On the `blk_ack` falling edge, moves to NEXT.
- NEXT:
  - Sets `err` if `byte_cnt` != `BLK_BYTES` or `blk_err`=1.
  - If `blk_idx` == latched count, moves to DONE.
  - Otherwise increments `blk_idx`, clears `byte_cnt` and returns to ISSUE.
- DONE: drops `sd_ack` and `busy`, then moves to IDLE.
- `sd_rd` or `sd_wr` dropping mid-sequence is ignored; the sequence always runs to completion.
- A request still high in the cycle after DONE is treated as new. Upstream clears its request while `sd_ack`=1, so this does not occur in normal use.
- Count range: `sd_blk_cnt` = 0..63 means 1..64 blocks. Counts above `MAX_BLKS`-1 are clamped to `MAX_BLKS`-1 and set `err`.

## Timing
- Reset values: `sd_ack`, `blk_rd`, `blk_wr`, `buff_we`, `busy`, `err` = 0; `blk_lba`, `buff_addr` = 0; state = IDLE.
- Asynchronous reset mid-transfer aborts immediately; all outputs return to reset values.
- Request seen high at clock edge N: `sd_ack`=1 after edge N+1; `blk_rd`/`blk_wr`=1 after edge N+2.
- `blk_rd`/`blk_wr` fall one cycle after `blk_ack` is sampled high.
- Block turnaround: from `blk_ack` sampled low to the next `blk_rd`/`blk_wr` is 2 cycles (NEXT, ISSUE).
- `sd_ack` falls 2 cycles after the last block's `blk_ack` is sampled low.
- `buff_addr` and `buff_we` are registered: valid one cycle after the `byte_stb` cycle. Back-to-back strobes are supported.
- `err` is updated in NEXT and held until the next accepted request.

## Configuration
- `C1541_SD_SEQ_RETRY_EN` defined:
  - A block ending with `blk_err`=1 or a short byte count is re-issued from ISSUE at the same `blk_idx`, with `byte_cnt` cleared.
  - Up to 2 retries per block; `err` is set only when the final retry also fails.
  - Each retry adds 2 cycles before the next request.
- Not defined: no retry; the failing block sets `err` and the sequence proceeds to the next block.

## Test plan
- Read, LBA 0x147, `sd_blk_cnt`=18 (track 17, 19 blocks):
  - `blk_lba` steps 0x147..0x159.
  - 9728 `buff_we` pulses, `buff_addr` 0..0x25FF.
  - `sd_ack` falls 2 cycles after the final `blk_ack` fall; `err`=0.
- Write, `sd_blk_cnt`=0x1F, LBA 5: 32 `blk_wr` requests, `buff_we` never asserted, `buff_addr` reaches 0x3FFF.
- `sd_rd` and `sd_wr` both high in the same cycle: `blk_wr` issued, no `blk_rd`.
- Block 3 delivers only 100 bytes:
  - Without the macro: `err`=1 after the sequence, all blocks still issued.
  - With the macro: block 3 is re-issued once, and a good retry leaves `err`=0.
- `reset_n` low during block 5 of 10: all outputs are 0 immediately; a new request after release starts from `blk_idx` 0.
- 520 strobes in a single block: `buff_we` only on the first 512, `buff_addr` holds 0x1FF, `err`=1.
